// File: rtl/coin_accept_conditioner_if.sv
// Button-side bundle between the raw push-buttons and the vending FSM input stage.
// The master drives the raw buttons; the conditioner (slave) returns pulses and levels.
interface coin_accept_conditioner_if;
    logic coin_btn;
    logic accept_btn;
    logic m;
    logic a;
    logic coin_held;
    logic accept_held;
    logic busy;

    modport master (
        output coin_btn, accept_btn,
        input  m, a, coin_held, accept_held, busy
    );

    modport slave (
        input  coin_btn, accept_btn,
        output m, a, coin_held, accept_held, busy
    );
endinterface

// File: rtl/coin_accept_conditioner.sv
// Turns raw bouncing coin/accept buttons into clean one-cycle m/a pulses for the vending FSM.
// Each channel has a 2-FF synchronizer, a debounce FSM and a one-shot; the arbiter sends m before a.
//
// state | meaning
// IDLE  | button released and stable
// ARM   | s2 high, counting toward an accepted press
// HIGH  | press accepted, waiting for release
// REL   | s2 low, counting toward an accepted release
module coin_accept_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input logic                      clk,
    input logic                      rst,
    coin_accept_conditioner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, HIGH, REL} state_t;

    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0] raw;
    logic [1:0] req;
    logic [1:0] held_nxt;
    logic [1:0] busy_nxt;

    assign raw = {bus.accept_btn, bus.coin_btn};

    // Channel 0 is coin, channel 1 is accept.
    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic             s1;
        logic             s2;
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             req_nxt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                state <= IDLE;
                cnt   <= '0;
            end else begin
                s1    <= raw[i];
                s2    <= s1;
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            req_nxt   = 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state_nxt = ARM;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                ARM: begin
                    if (!s2) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_TC) begin
                        state_nxt = HIGH;
                        req_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state_nxt = REL;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                REL: begin
                    if (s2) begin
                        state_nxt = HIGH;
                    end else if (cnt == CNT_TC) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign req[i]      = req_nxt;
        assign held_nxt[i] = (state_nxt == HIGH) || (state_nxt == REL);
        assign busy_nxt[i] = (state_nxt != IDLE);
    end

    logic       m_q;
    logic       a_q;
    logic       a_pend;
    logic [1:0] held_q;
    logic       busy_q;

    // Coin wins a same-edge tie; the accept request is parked one cycle in a_pend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= 1'b0;
            a_q    <= 1'b0;
            a_pend <= 1'b0;
            held_q <= '0;
            busy_q <= 1'b0;
        end else begin
            m_q    <= req[0];
            a_q    <= (req[1] & ~req[0]) | a_pend;
            a_pend <= req[1] & req[0];
            held_q <= held_nxt;
            busy_q <= |busy_nxt;
        end
    end

    assign bus.m           = m_q;
    assign bus.a           = a_q;
    assign bus.coin_held   = held_q[0];
    assign bus.accept_held = held_q[1];
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_coin_accept_conditioner.sv
// Self-checking bench for coin_accept_conditioner with DEBOUNCE_CYCLES=4: directed scenarios
// plus random bouncy stimulus, all compared against a run-length debounce reference model.
module tb_coin_accept_conditioner;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    coin_accept_conditioner_if bus ();

    coin_accept_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: a channel's debounced level flips once DEB consecutive synchronized
    // samples disagree with it; a press is a 0->1 flip. Coin wins ties, accept follows.
    bit [1:0] sc, sa;
    int       run_c, run_a;
    bit       deb_c, deb_a, pend, m_exp, a_exp;

    always @(posedge clk or posedge rst) begin : ref_model
        int nc, na;
        bit dc, da, rc, ra;
        if (rst) begin
            sc <= 2'b00; sa <= 2'b00;
            run_c <= 0; run_a <= 0;
            deb_c <= 1'b0; deb_a <= 1'b0;
            pend <= 1'b0; m_exp <= 1'b0; a_exp <= 1'b0;
        end else begin
            nc = (sc[1] != deb_c) ? run_c + 1 : 0;
            dc = deb_c; rc = 1'b0;
            if (nc == DEB) begin dc = !deb_c; nc = 0; rc = dc; end
            na = (sa[1] != deb_a) ? run_a + 1 : 0;
            da = deb_a; ra = 1'b0;
            if (na == DEB) begin da = !deb_a; na = 0; ra = da; end
            sc <= {sc[0], bus.coin_btn};
            sa <= {sa[0], bus.accept_btn};
            run_c <= nc; run_a <= na;
            deb_c <= dc; deb_a <= da;
            m_exp <= rc;
            a_exp <= (ra && !rc) || pend;
            pend  <= ra && rc;
        end
    end

    wire       busy_exp = deb_c || (run_c != 0) || deb_a || (run_a != 0);
    wire [4:0] exp_vec  = {m_exp, a_exp, deb_c, deb_a, busy_exp};
    wire [4:0] dut_vec  = {bus.m, bus.a, bus.coin_held, bus.accept_held, bus.busy};

    task automatic test_reset();
        rst = 1'b1;
        bus.coin_btn = 1'b0;
        bus.accept_btn = 1'b0;
        #2;
        n_checks++;
        if (dut_vec !== 5'b0) begin
            n_fail++; $display("FAIL reset_async: got %b expected %b", dut_vec, 5'b0);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec !== 5'b0) begin
            n_fail++; $display("FAIL reset_held: got %b expected %b", dut_vec, 5'b0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec !== 5'b0) begin
            n_fail++; $display("FAIL reset_idle: got %b expected %b", dut_vec, 5'b0);
        end
    endtask

    task automatic test_clean_press();
        bus.coin_btn = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m !== (e == 5)) begin
                n_fail++; $display("FAIL clean_m e=%0d: got %b expected %b", e, bus.m, e == 5);
            end
            n_checks++;
            if (bus.coin_held !== (e >= 5 && e < 25)) begin
                n_fail++; $display("FAIL clean_held e=%0d: got %b expected %b", e, bus.coin_held, e >= 5 && e < 25);
            end
            n_checks++;
            if (bus.busy !== (e >= 2 && e < 25)) begin
                n_fail++; $display("FAIL clean_busy e=%0d: got %b expected %b", e, bus.busy, e >= 2 && e < 25);
            end
            n_checks++;
            if (bus.a !== 1'b0) begin
                n_fail++; $display("FAIL clean_a e=%0d: got %b expected 0", e, bus.a);
            end
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL clean_model e=%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
            bus.coin_btn = (e + 1 < 20);
        end
    endtask

    task automatic test_bounce();
        bit pat[50];
        bit p8[8] = '{1, 1, 1, 0, 1, 1, 0, 1};
        int a_rel = 0;
        for (int p = 0; p < 50; p++) begin
            if (p < 8)       pat[p] = p8[p];
            else if (p < 30) pat[p] = 1'b1;
            else if (p < 32) pat[p] = 1'b0;
            else if (p < 34) pat[p] = 1'b1;
            else             pat[p] = 1'b0;
        end
        bus.accept_btn = pat[0];
        for (int e = 0; e < 50; e++) begin
            @(negedge clk);
            if (e < 30) begin
                n_checks++;
                if (bus.a !== (e == 12)) begin
                    n_fail++; $display("FAIL bounce_a e=%0d: got %b expected %b", e, bus.a, e == 12);
                end
            end else if (bus.a) begin
                a_rel++;
            end
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL bounce_model e=%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
            if (e < 49) bus.accept_btn = pat[e + 1];
        end
        n_checks++;
        if (a_rel !== 0) begin
            n_fail++; $display("FAIL release_glitch_pulses: got %0d expected 0", a_rel);
        end
        n_checks++;
        if (bus.accept_held !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL release_glitch_idle: got held=%b busy=%b expected 0 0", bus.accept_held, bus.busy);
        end
    endtask

    task automatic test_simultaneous();
        int m_at = -1;
        int a_at = -1;
        bus.coin_btn = 1'b1;
        bus.accept_btn = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            if (bus.m && m_at < 0) m_at = e;
            if (bus.a && a_at < 0) a_at = e;
            n_checks++;
            if (bus.m && bus.a) begin
                n_fail++; $display("FAIL simul_overlap e=%0d: got m=1 a=1 expected not both", e);
            end
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL simul_model e=%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
            if (e == 15) begin bus.coin_btn = 1'b0; bus.accept_btn = 1'b0; end
        end
        n_checks++;
        if (m_at !== 5 || a_at !== 6) begin
            n_fail++; $display("FAIL simul_order: got m@%0d a@%0d expected m@5 a@6", m_at, a_at);
        end
    endtask

    task automatic test_reset_mid_press();
        int m_cnt = 0;
        int m_at  = -1;
        bus.coin_btn = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_armed: got busy=%b expected 1", bus.busy);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== 5'b0) begin
            n_fail++; $display("FAIL midrst_async: got %b expected %b", dut_vec, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (bus.m) begin m_cnt++; m_at = e; end
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL midrst_model e=%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (m_cnt !== 1 || m_at !== 6) begin
            n_fail++; $display("FAIL midrst_pulse: got %0d pulses last@%0d expected 1 @6", m_cnt, m_at);
        end
        bus.coin_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_long_hold();
        int  m_cnt = 0;
        bit  saw_idle = 1'b0;
        bus.coin_btn = 1'b1;
        for (int e = 0; e < 1050; e++) begin
            @(negedge clk);
            if (bus.m) m_cnt++;
            if (e >= 1000 && e < 1010 && !bus.busy) saw_idle = 1'b1;
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL long_model e=%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
            if (e == 998)  bus.coin_btn = 1'b0;
            if (e == 1008) bus.coin_btn = 1'b1;
            if (e == 1040) bus.coin_btn = 1'b0;
        end
        n_checks++;
        if (m_cnt !== 2) begin
            n_fail++; $display("FAIL long_pulses: got %0d expected 2", m_cnt);
        end
        n_checks++;
        if (saw_idle !== 1'b1) begin
            n_fail++; $display("FAIL long_busy_gap: got busy never low expected a low gap");
        end
    endtask

    task automatic test_random();
        int left_c = 0;
        int left_a = 0;
        for (int e = 0; e < 3000; e++) begin
            if (left_c == 0) begin
                bus.coin_btn = $urandom_range(0, 1);
                left_c = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 5);
            end
            if (left_a == 0) begin
                bus.accept_btn = $urandom_range(0, 1);
                left_a = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 5);
            end
            left_c--;
            left_a--;
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; $display("FAIL random_model e=%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
            n_checks++;
            if (bus.m && bus.a) begin
                n_fail++; $display("FAIL random_overlap e=%0d: got m=1 a=1 expected not both", e);
            end
        end
        bus.coin_btn = 1'b0;
        bus.accept_btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        bus.coin_btn = 1'b0;
        bus.accept_btn = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_press();
        test_long_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
